// File: rtl/stopwatch_pkg.sv
// Shared types and field layout for the stopwatch/countdown timer.
// Packed time is {hr_h, hr_l, min_h, min_l, sec_h, sec_l}, one BCD digit per nibble.
package stopwatch_pkg;

  localparam int DIG_W  = 4;
  localparam int TIME_W = 24;

  localparam int OFS_SEC_L = 0;
  localparam int OFS_SEC_H = 4;
  localparam int OFS_MIN_L = 8;
  localparam int OFS_MIN_H = 12;
  localparam int OFS_HR_L  = 16;
  localparam int OFS_HR_H  = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A minutes/seconds pair with any illegal digit collapses to 59.
  function automatic logic [7:0] sat_ms(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 8'h59;
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit counting 0..MAX with wrap, load and clear.
// carry/borrow are combinational and only asserted while the matching step is requested.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [DIG_W-1:0] MAX = 4'd9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             ld_i,
  input  logic [DIG_W-1:0] ld_val_i,
  input  logic             clr_i,
  output logic [DIG_W-1:0] q_o,
  output logic             carry_o,
  output logic             borrow_o
);

  logic [DIG_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)       q_d = '0;
    else if (ld_i)   q_d = ld_val_i;
    else if (inc_i)  q_d = (q_q == MAX) ? '0 : q_q + DIG_W'(1);
    else if (dec_i)  q_d = (q_q == '0) ? MAX : q_q - DIG_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o      = q_q;
  assign carry_o  = inc_i && (q_q == MAX);
  assign borrow_o = dec_i && (q_q == '0);

endmodule

// File: rtl/stopwatch_timer.sv
// Six-digit BCD stopwatch / countdown timer driven by a clock-enable prescaler.
// Holds the control FSM, prescaler, hour pair, lap register and preset saturation.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV    = 10_000_000,
  parameter int unsigned HR_MAX = 99
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_stop_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [TIME_W-1:0] preset_i,
  input  logic              down_i,
  input  logic              lap_i,
  output logic [TIME_W-1:0] time_bcd_o,
  output logic [TIME_W-1:0] lap_time_o,
  output logic              lap_valid_o,
  output logic              running_o,
  output logic              done_o,
  output logic              wrap_o
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
  localparam logic [7:0]        HR_MAX_BCD = {4'(HR_MAX / 10), 4'(HR_MAX % 10)};
  localparam logic [TIME_W-1:0] TIME_MAX   = {HR_MAX_BCD, 16'h5959};

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              running_q;
  logic [TIME_W-1:0] lap_time_q;
  logic              lap_valid_q;
  logic [7:0]        hr_q, hr_d;

  logic [DIG_W-1:0]  sec_l, sec_h, min_l, min_h;
  logic              c_sec_l, c_sec_h, c_min_l, c_min_h;
  logic              b_sec_l, b_sec_h, b_min_l, b_min_h;
  logic [TIME_W-1:0] time_now;
  logic              is_zero, is_one, load_acc, tick, up_tick, dn_tick;
  logic [7:0]        sec_ld, min_ld, hr_ld;

  function automatic logic [7:0] sat_hr(input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > HR_MAX_BCD) return HR_MAX_BCD;
    return v;
  endfunction

  assign time_now = {hr_q, min_h, min_l, sec_h, sec_l};
  assign is_zero  = (time_now == '0);
  assign is_one   = (time_now == TIME_W'(1));
  assign load_acc = load_i && !clear_i && (state_q != ST_RUN);
  // Load is ignored in RUN, so only clear and start_stop can pre-empt a tick.
  assign tick     = (state_q == ST_RUN) && !clear_i && !start_stop_i && (presc_q == PRESC_LAST);
  assign up_tick  = tick && !down_i;
  assign dn_tick  = tick && down_i && !is_zero;

  assign sec_ld = sat_ms(preset_i[OFS_SEC_L +: 8]);
  assign min_ld = sat_ms(preset_i[OFS_MIN_L +: 8]);
  assign hr_ld  = sat_hr(preset_i[OFS_HR_L +: 8]);

  bcd_digit #(.MAX(4'd9)) u_sec_l (
    .clk(clk), .rst_n(rst_n), .inc_i(up_tick), .dec_i(dn_tick), .ld_i(load_acc),
    .ld_val_i(sec_ld[3:0]), .clr_i(clear_i), .q_o(sec_l), .carry_o(c_sec_l), .borrow_o(b_sec_l)
  );
  bcd_digit #(.MAX(4'd5)) u_sec_h (
    .clk(clk), .rst_n(rst_n), .inc_i(c_sec_l), .dec_i(b_sec_l), .ld_i(load_acc),
    .ld_val_i(sec_ld[7:4]), .clr_i(clear_i), .q_o(sec_h), .carry_o(c_sec_h), .borrow_o(b_sec_h)
  );
  bcd_digit #(.MAX(4'd9)) u_min_l (
    .clk(clk), .rst_n(rst_n), .inc_i(c_sec_h), .dec_i(b_sec_h), .ld_i(load_acc),
    .ld_val_i(min_ld[3:0]), .clr_i(clear_i), .q_o(min_l), .carry_o(c_min_l), .borrow_o(b_min_l)
  );
  bcd_digit #(.MAX(4'd5)) u_min_h (
    .clk(clk), .rst_n(rst_n), .inc_i(c_min_l), .dec_i(b_min_l), .ld_i(load_acc),
    .ld_val_i(min_ld[7:4]), .clr_i(clear_i), .q_o(min_h), .carry_o(c_min_h), .borrow_o(b_min_h)
  );

  // Hour pair wraps at HR_MAX rather than at a per-digit limit.
  always_comb begin
    hr_d = hr_q;
    if (clear_i) begin
      hr_d = '0;
    end else if (load_acc) begin
      hr_d = hr_ld;
    end else if (c_min_h) begin
      if (hr_q == HR_MAX_BCD)     hr_d = '0;
      else if (hr_q[3:0] == 4'd9) hr_d = {hr_q[7:4] + 4'd1, 4'd0};
      else                        hr_d = {hr_q[7:4], hr_q[3:0] + 4'd1};
    end else if (b_min_h) begin
      if (hr_q == '0)             hr_d = HR_MAX_BCD;
      else if (hr_q[3:0] == 4'd0) hr_d = {hr_q[7:4] - 4'd1, 4'd9};
      else                        hr_d = {hr_q[7:4], hr_q[3:0] - 4'd1};
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else if (load_acc) begin
      state_d = ST_PAUSE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_stop_i) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
        ST_RUN: begin
          if (start_stop_i) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (down_i) begin
              if (is_zero || is_one) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else if (time_now == TIME_MAX) begin
              wrap_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: if (start_stop_i) state_d = ST_RUN;
        ST_DONE:  ;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      running_q   <= 1'b0;
      hr_q        <= '0;
      lap_time_q  <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == ST_RUN);
      hr_q      <= hr_d;
      if (clear_i) begin
        lap_time_q  <= '0;
        lap_valid_q <= 1'b0;
      end else if (lap_i && state_q != ST_IDLE) begin
        lap_time_q  <= time_now;
        lap_valid_q <= 1'b1;
      end
    end
  end

  assign time_bcd_o  = time_now;
  assign lap_time_o  = lap_time_q;
  assign lap_valid_o = lap_valid_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;

endmodule
